// File: rtl/ifu_pkg.sv
// Shared definitions for the fetch-PC generator: FSM encodings and parameter defaults.
package ifu_pkg;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT  = 2'd0;
    localparam pc_state_t ST_FETCH = 2'd1;
    localparam pc_state_t ST_PEND  = 2'd2;
    localparam pc_state_t ST_ERR   = 2'd3;

    localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
    localparam int          EPOCH_W_DEF   = 2;

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: lowest asserted index wins, target muxed through a one-hot grant.
module pc_redir_arb #(
    parameter int NUM_REDIR = 3,
    parameter int ADDR_W    = 32
) (
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
    output logic                        win_valid,
    output logic [ADDR_W-1:0]           win_target
);

    logic [NUM_REDIR-1:0] grant;

    // Scan from lowest priority upward so the highest-priority source overwrites last.
    always_comb begin
        grant = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        win_target = '0;
        for (int i = 0; i < NUM_REDIR; i++) begin
            win_target = win_target | ({ADDR_W{grant[i]}} & redir_target[i*ADDR_W +: ADDR_W]);
        end
    end

    assign win_valid = |redir_valid;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-PC generator with prioritised redirects, valid/ready issue and epoch tagging.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | normal sequential / redirect issue
// PEND  | redirect captured while a request is still waiting for ready
// ERR   | misaligned redirect seen; idle until an aligned redirect (PC_ALIGN_CHECK_EN only)
module pc_gen_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(RESET_VEC_DEF),
    parameter int                FETCH_BYTES = 4,
    parameter int                NUM_REDIR   = 3,
    parameter int                EPOCH_W     = EPOCH_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [NUM_REDIR-1:0]        redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
    output logic                        fetch_valid,
    input  logic                        fetch_ready,
    output logic [ADDR_W-1:0]           fetch_pc,
    output logic [EPOCH_W-1:0]          fetch_epoch,
    output logic [EPOCH_W-1:0]          cur_epoch,
    output logic                        adel
);

    pc_state_t          state;
    logic [ADDR_W-1:0]  pend_target;
    logic               win_valid;
    logic [ADDR_W-1:0]  win_target;
    logic               win_ok;
    logic               win_bad;
    logic               hs;
    logic [EPOCH_W-1:0] epoch_inc;

    pc_redir_arb #(
        .NUM_REDIR (NUM_REDIR),
        .ADDR_W    (ADDR_W)
    ) u_arb (
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .win_valid    (win_valid),
        .win_target   (win_target)
    );

    assign hs        = fetch_valid & fetch_ready;
    assign epoch_inc = cur_epoch + EPOCH_W'(1);

`ifdef PC_ALIGN_CHECK_EN
    assign win_bad = win_valid & (win_target[1:0] != 2'b00);
`else
    assign win_bad = 1'b0;
    assign adel    = 1'b0;
`endif
    assign win_ok = win_valid & ~win_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_VEC;
            fetch_valid <= 1'b0;
            fetch_epoch <= '0;
            cur_epoch   <= '0;
            pend_target <= '0;
`ifdef PC_ALIGN_CHECK_EN
            adel        <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            adel <= 1'b0;
`endif
            case (state)
                ST_BOOT: state <= ST_FETCH;

                ST_FETCH: begin
                    if (win_ok) begin
                        cur_epoch <= epoch_inc;
                        if (!fetch_valid || hs) begin
                            fetch_pc    <= win_target;
                            fetch_epoch <= epoch_inc;
                            fetch_valid <= ~stall;
                        end else begin
                            pend_target <= win_target;
                            state       <= ST_PEND;
                        end
                    end
`ifdef PC_ALIGN_CHECK_EN
                    else if (win_bad) begin
                        adel        <= 1'b1;
                        cur_epoch   <= epoch_inc;
                        fetch_valid <= fetch_valid & ~fetch_ready;
                        state       <= ST_ERR;
                    end
`endif
                    else if (hs) begin
                        fetch_pc    <= fetch_pc + ADDR_W'(FETCH_BYTES);
                        fetch_valid <= ~stall;
                    end else if (!fetch_valid && !stall) begin
                        fetch_valid <= 1'b1;
                    end
                end

                ST_PEND: begin
                    // A newer winner arriving on the handshake cycle is issued directly.
                    if (win_ok) begin
                        cur_epoch <= epoch_inc;
                        if (hs) begin
                            fetch_pc    <= win_target;
                            fetch_epoch <= epoch_inc;
                            fetch_valid <= ~stall;
                            state       <= ST_FETCH;
                        end else begin
                            pend_target <= win_target;
                        end
                    end
`ifdef PC_ALIGN_CHECK_EN
                    else if (win_bad) begin
                        adel        <= 1'b1;
                        cur_epoch   <= epoch_inc;
                        fetch_valid <= fetch_valid & ~fetch_ready;
                        state       <= ST_ERR;
                    end
`endif
                    else if (hs) begin
                        fetch_pc    <= pend_target;
                        fetch_epoch <= cur_epoch;
                        fetch_valid <= ~stall;
                        state       <= ST_FETCH;
                    end
                end

`ifdef PC_ALIGN_CHECK_EN
                ST_ERR: begin
                    // An in-flight request is never retracted; valid drops once it is accepted.
                    if (win_ok) begin
                        cur_epoch <= epoch_inc;
                        if (!fetch_valid || hs) begin
                            fetch_pc    <= win_target;
                            fetch_epoch <= epoch_inc;
                            fetch_valid <= ~stall;
                            state       <= ST_FETCH;
                        end else begin
                            pend_target <= win_target;
                            state       <= ST_PEND;
                        end
                    end else if (win_bad) begin
                        adel        <= 1'b1;
                        cur_epoch   <= epoch_inc;
                        fetch_valid <= fetch_valid & ~fetch_ready;
                    end else if (hs) begin
                        fetch_valid <= 1'b0;
                    end
                end
`endif

                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  redir_valid;
    logic [95:0] redir_target;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_epoch;
    logic [1:0]  cur_epoch;
    logic        adel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .ADDR_W      (32),
        .RESET_VEC   (RV),
        .FETCH_BYTES (4),
        .NUM_REDIR   (3),
        .EPOCH_W     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_epoch  (fetch_epoch),
        .cur_epoch    (cur_epoch),
        .adel         (adel)
    );

    task automatic do_reset(input logic st);
        rst          = 1'b1;
        stall        = st;
        fetch_ready  = 1'b0;
        redir_valid  = '0;
        redir_target = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 10 && fetch_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_valid: fetch_valid=%b required 1 within 10 cycles", tag, fetch_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0; redir_valid = '0; redir_target = '0;
        @(negedge clk);
        checks += 5;
        if (fetch_pc !== RV) begin errors++; $display("FAIL reset_pc: got %h exp %h", fetch_pc, RV); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", fetch_valid); end
        if (fetch_epoch !== 2'd0) begin errors++; $display("FAIL reset_fepoch: got %0d exp 0", fetch_epoch); end
        if (cur_epoch !== 2'd0) begin errors++; $display("FAIL reset_cepoch: got %0d exp 0", cur_epoch); end
        if (adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b exp 0", adel); end
    endtask

    task automatic test_sequential();
        do_reset(1'b0);
        fetch_ready = 1'b1;
        wait_valid("seq");
        for (int n = 0; n < 3; n++) begin
            checks += 3;
            if (fetch_pc !== RV + 32'(4 * n)) begin
                errors++; $display("FAIL seq_pc%0d: got %h exp %h", n, fetch_pc, RV + 32'(4 * n));
            end
            if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b exp 1", n, fetch_valid); end
            if (fetch_epoch !== 2'd0) begin errors++; $display("FAIL seq_epoch%0d: got %0d exp 0", n, fetch_epoch); end
            @(negedge clk);
        end
        fetch_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset(1'b0);
        wait_valid("hold");
        for (int n = 0; n < 3; n++) begin
            if (n == 1) stall = 1'b1;
            @(negedge clk);
            checks += 2;
            if (fetch_pc !== RV) begin errors++; $display("FAIL hold_pc%0d: got %h exp %h", n, fetch_pc, RV); end
            if (fetch_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b exp 1", n, fetch_valid); end
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (fetch_pc !== RV + 32'd4) begin errors++; $display("FAIL hold_adv_pc: got %h exp %h", fetch_pc, RV + 32'd4); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL hold_stall_valid: got %b exp 0", fetch_valid); end
        @(negedge clk);
        checks += 2;
        if (fetch_pc !== RV + 32'd4) begin errors++; $display("FAIL hold_idle_pc: got %h exp %h", fetch_pc, RV + 32'd4); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL hold_idle_valid: got %b exp 0", fetch_valid); end
        stall = 1'b0; fetch_ready = 1'b0;
    endtask

    task automatic test_redir_idle();
        do_reset(1'b1);
        redir_target[32 +: 32] = 32'h8000_0180;
        redir_target[64 +: 32] = 32'h9FC0_0000;
        redir_valid = 3'b110;
        stall = 1'b0;
        @(negedge clk);
        redir_valid = '0;
        checks += 4;
        if (fetch_pc !== 32'h8000_0180) begin errors++; $display("FAIL ridle_pc: got %h exp 80000180", fetch_pc); end
        if (cur_epoch !== 2'd1) begin errors++; $display("FAIL ridle_cepoch: got %0d exp 1", cur_epoch); end
        if (fetch_epoch !== 2'd1) begin errors++; $display("FAIL ridle_fepoch: got %0d exp 1", fetch_epoch); end
        if (fetch_valid !== 1'b1) begin errors++; $display("FAIL ridle_valid: got %b exp 1", fetch_valid); end
    endtask

    task automatic enter_pend(input string tag);
        do_reset(1'b0);
        wait_valid(tag);
        redir_target[0 +: 32] = 32'h8000_1000;
        redir_valid = 3'b001;
        @(negedge clk);
        redir_valid = '0;
    endtask

    task automatic test_redir_pend();
        enter_pend("rpend");
        checks += 4;
        if (cur_epoch !== 2'd1) begin errors++; $display("FAIL rpend_cepoch: got %0d exp 1", cur_epoch); end
        if (fetch_epoch !== 2'd0) begin errors++; $display("FAIL rpend_fepoch_old: got %0d exp 0", fetch_epoch); end
        if (fetch_pc !== RV) begin errors++; $display("FAIL rpend_pc_old: got %h exp %h", fetch_pc, RV); end
        if (fetch_valid !== 1'b1) begin errors++; $display("FAIL rpend_valid: got %b exp 1", fetch_valid); end
        @(negedge clk);
        checks++;
        if (fetch_pc !== RV) begin errors++; $display("FAIL rpend_pc_held: got %h exp %h", fetch_pc, RV); end
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        checks += 3;
        if (fetch_pc !== 32'h8000_1000) begin errors++; $display("FAIL rpend_pc_new: got %h exp 80001000", fetch_pc); end
        if (fetch_epoch !== 2'd1) begin errors++; $display("FAIL rpend_fepoch_new: got %0d exp 1", fetch_epoch); end
        if (fetch_valid !== 1'b1) begin errors++; $display("FAIL rpend_valid_new: got %b exp 1", fetch_valid); end
    endtask

    task automatic test_reset_mid_pend();
        enter_pend("rstp");
        rst = 1'b1;
        #1;
        checks += 4;
        if (fetch_pc !== RV) begin errors++; $display("FAIL rstp_pc: got %h exp %h", fetch_pc, RV); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid: got %b exp 0", fetch_valid); end
        if (cur_epoch !== 2'd0) begin errors++; $display("FAIL rstp_cepoch: got %0d exp 0", cur_epoch); end
        if (fetch_epoch !== 2'd0) begin errors++; $display("FAIL rstp_fepoch: got %0d exp 0", fetch_epoch); end
        @(negedge clk);
        rst = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clk);
        wait_valid("rstp");
        checks++;
        if (fetch_pc !== RV) begin errors++; $display("FAIL rstp_first_pc: got %h exp %h", fetch_pc, RV); end
        @(negedge clk);
        checks++;
        if (fetch_pc !== RV + 32'd4) begin errors++; $display("FAIL rstp_no_pend: got %h exp %h", fetch_pc, RV + 32'd4); end
        fetch_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        redir_target[0 +: 32] = 32'hFFFF_FFFC;
        redir_valid = 3'b001;
        stall = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clk);
        redir_valid = '0;
        stall = 1'b1;
        checks += 2;
        if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load: got %h exp FFFFFFFC", fetch_pc); end
        if (cur_epoch !== 2'd1) begin errors++; $display("FAIL wrap_cepoch: got %0d exp 1", cur_epoch); end
        @(negedge clk);
        checks += 2;
        if (fetch_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h exp 00000000", fetch_pc); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b exp 0", fetch_valid); end
        redir_target[0 +: 32] = 32'h0000_1000;
        for (int n = 0; n < 3; n++) begin
            redir_valid = 3'b001;
            @(negedge clk);
        end
        redir_valid = '0;
        checks += 3;
        if (cur_epoch !== 2'd0) begin errors++; $display("FAIL epoch_wrap: got %0d exp 0", cur_epoch); end
        if (fetch_pc !== 32'h0000_1000) begin errors++; $display("FAIL epoch_wrap_pc: got %h exp 00001000", fetch_pc); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL epoch_wrap_valid: got %b exp 0", fetch_valid); end
        stall = 1'b0; fetch_ready = 1'b0;
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_align();
        do_reset(1'b1);
        redir_target[32 +: 32] = 32'h8000_0002;
        redir_valid = 3'b010;
        stall = 1'b0;
        @(negedge clk);
        redir_valid = '0;
        checks += 4;
        if (adel !== 1'b1) begin errors++; $display("FAIL align_adel: got %b exp 1", adel); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL align_valid: got %b exp 0", fetch_valid); end
        if (cur_epoch !== 2'd1) begin errors++; $display("FAIL align_cepoch: got %0d exp 1", cur_epoch); end
        if (fetch_pc !== RV) begin errors++; $display("FAIL align_pc: got %h exp %h", fetch_pc, RV); end
        @(negedge clk);
        checks += 2;
        if (adel !== 1'b0) begin errors++; $display("FAIL align_pulse: got %b exp 0", adel); end
        if (fetch_valid !== 1'b0) begin errors++; $display("FAIL align_err_valid: got %b exp 0", fetch_valid); end
        redir_target[32 +: 32] = 32'h8000_0004;
        redir_valid = 3'b010;
        @(negedge clk);
        redir_valid = '0;
        checks += 4;
        if (fetch_pc !== 32'h8000_0004) begin errors++; $display("FAIL align_resume_pc: got %h exp 80000004", fetch_pc); end
        if (fetch_valid !== 1'b1) begin errors++; $display("FAIL align_resume_valid: got %b exp 1", fetch_valid); end
        if (fetch_epoch !== 2'd2) begin errors++; $display("FAIL align_resume_epoch: got %0d exp 2", fetch_epoch); end
        if (adel !== 1'b0) begin errors++; $display("FAIL align_resume_adel: got %b exp 0", adel); end
    endtask
`else
    task automatic test_no_align();
        do_reset(1'b1);
        redir_target[32 +: 32] = 32'h8000_0002;
        redir_valid = 3'b010;
        stall = 1'b0;
        @(negedge clk);
        redir_valid = '0;
        checks += 3;
        if (fetch_pc !== 32'h8000_0002) begin errors++; $display("FAIL noalign_pc: got %h exp 80000002", fetch_pc); end
        if (adel !== 1'b0) begin errors++; $display("FAIL noalign_adel: got %b exp 0", adel); end
        if (cur_epoch !== 2'd1) begin errors++; $display("FAIL noalign_cepoch: got %0d exp 1", cur_epoch); end
    endtask
`endif

    // Reference: one outstanding request at most, a remembered pending target, epochs counted per redirect.
    task automatic test_random();
        logic [31:0] m_pc = RV;
        logic        m_valid = 1'b0;
        logic [1:0]  m_cur = 2'd0;
        logic [1:0]  m_tag = 2'd0;
        logic        m_has_pend = 1'b0;
        logic [31:0] m_pend = '0;
        logic        win;
        logic [31:0] wt;
        logic        accepted;
        do_reset(1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks += 5;
            if (fetch_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", cyc, fetch_valid, m_valid); end
            if (fetch_pc !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h exp %h", cyc, fetch_pc, m_pc); end
            if (fetch_epoch !== m_tag) begin errors++; $display("FAIL rnd_fepoch c%0d: got %0d exp %0d", cyc, fetch_epoch, m_tag); end
            if (cur_epoch !== m_cur) begin errors++; $display("FAIL rnd_cepoch c%0d: got %0d exp %0d", cyc, cur_epoch, m_cur); end
            if (adel !== 1'b0) begin errors++; $display("FAIL rnd_adel c%0d: got %b exp 0", cyc, adel); end

            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 3; i++) begin
                redir_valid[i] = ($urandom_range(0, 9) == 0);
                redir_target[i*32 +: 32] = $urandom() & 32'hFFFF_FFFC;
            end

            win = 1'b0;
            wt  = '0;
            for (int i = 0; i < 3; i++) begin
                if (redir_valid[i] && !win) begin
                    win = 1'b1;
                    wt  = redir_target[i*32 +: 32];
                end
            end
            accepted = m_valid && fetch_ready;

            if (win) begin
                m_cur = m_cur + 2'd1;
                if (!m_valid || accepted) begin
                    m_pc = wt; m_tag = m_cur; m_valid = !stall; m_has_pend = 1'b0;
                end else begin
                    m_pend = wt; m_has_pend = 1'b1;
                end
            end else if (accepted) begin
                m_pc = m_has_pend ? m_pend : m_pc + 32'd4;
                if (m_has_pend) m_tag = m_cur;
                m_has_pend = 1'b0;
                m_valid = !stall;
            end else if (!m_valid && !stall) begin
                m_valid = 1'b1;
            end

            @(negedge clk);
        end
        redir_valid = '0; stall = 1'b0; fetch_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_redir_idle();
        test_redir_pend();
        test_reset_mid_pend();
        test_wrap();
`ifdef PC_ALIGN_CHECK_EN
        test_align();
`else
        test_no_align();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
